// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the multi-cycle ALU execution unit: word size,
// the 16 ALU control codes produced by the control decoder, and FSM states.
package alu_exec_unit_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_ORR = 4'h3,
        OP_NOT = 4'h4,
        OP_TCP = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_ADI = 4'h8,
        OP_ORI = 4'h9,
        OP_LHI = 4'hA,
        OP_MEM = 4'hB,
        OP_BNE = 4'hC,
        OP_BEQ = 4'hD,
        OP_BGZ = 4'hE,
        OP_BLZ = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Branch codes occupy the top quarter of the code space (C..F).
    function automatic logic is_branch(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: control code and two operands in, result and branch condition out.
// Build option ALU_FLAGS_EN adds the {Z, N, C, V} flag output.
module alu_core #(
    parameter int W = 16
) (
    input  logic [3:0]   op_code_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         bcond_o
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]   flags_o
`endif
);
    import alu_exec_unit_pkg::*;

`ifdef ALU_FLAGS_EN
    logic [W:0] sum_w;
    logic [W:0] diff_w;

    // The extra top bit of diff_w is the not-borrow (carry out of A + ~B + 1).
    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
`else
    logic [W-1:0] sum_w;
    logic [W-1:0] diff_w;

    assign sum_w  = a_i + b_i;
    assign diff_w = a_i - b_i;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result_o = diff_w[W-1:0];
        bcond_o  = 1'b0;
        case (op_code_i)
            OP_ADD, OP_ADI, OP_MEM: result_o = sum_w[W-1:0];
            OP_SUB:                 result_o = diff_w[W-1:0];
            OP_AND:                 result_o = a_i & b_i;
            OP_ORR, OP_ORI:         result_o = a_i | b_i;
            OP_NOT:                 result_o = ~a_i;
            OP_TCP:                 result_o = ~a_i + {{(W-1){1'b0}}, 1'b1};
            OP_SHL:                 result_o = {a_i[W-2:0], 1'b0};
            OP_SHR:                 result_o = {a_i[W-1], a_i[W-1:1]};
            OP_LHI:                 result_o = {b_i[7:0], {(W-8){1'b0}}};
            OP_BNE:                 bcond_o  = (a_i != b_i);
            OP_BEQ:                 bcond_o  = (a_i == b_i);
            OP_BGZ:                 bcond_o  = !a_i[W-1] && (a_i != '0);
            OP_BLZ:                 bcond_o  = a_i[W-1];
            default: ;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic add_form;
    logic sub_form;

    always_comb begin
        add_form = (op_code_i == OP_ADD) || (op_code_i == OP_ADI) || (op_code_i == OP_MEM);
        sub_form = (op_code_i == OP_SUB) || is_branch(op_code_i);
        flags_o  = {result_o == '0, result_o[W-1], 1'b0, 1'b0};
        if (add_form) begin
            flags_o[1] = sum_w[W];
            flags_o[0] = (a_i[W-1] == b_i[W-1]) && (sum_w[W-1] != a_i[W-1]);
        end else if (sub_form) begin
            flags_o[1] = diff_w[W];
            flags_o[0] = (a_i[W-1] != b_i[W-1]) && (diff_w[W-1] != a_i[W-1]);
        end
    end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked multi-cycle ALU: accepts one op in IDLE, busies for 1+EXTRA_LAT cycles,
// then holds result/bcond until accepted. Build option ALU_FLAGS_EN adds a flags output.
module alu_exec_unit #(
    parameter int WORD_SIZE = alu_exec_unit_pkg::WORD_SIZE,
    parameter int EXTRA_LAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op_code,
    input  logic [WORD_SIZE-1:0] op_a,
    input  logic [WORD_SIZE-1:0] op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] result,
    output logic                 bcond
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]           flags
`endif
);
    import alu_exec_unit_pkg::*;

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [3:0]           op_q;
    logic [WORD_SIZE-1:0] a_q;
    logic [WORD_SIZE-1:0] b_q;
    logic [WORD_SIZE-1:0] result_q;
    logic                 bcond_q;
    logic [WORD_SIZE-1:0] result_d;
    logic                 bcond_d;
`ifdef ALU_FLAGS_EN
    logic [3:0]           flags_q;
    logic [3:0]           flags_d;
`endif

    // The core sees only the captured operands, so input changes after accept are invisible.
    alu_core #(
        .W (WORD_SIZE)
    ) u_alu_core (
        .op_code_i (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .result_o  (result_d),
        .bcond_o   (bcond_d)
`ifdef ALU_FLAGS_EN
        ,
        .flags_o   (flags_d)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            bcond_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= op_code;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        cnt_q   <= 4'(EXTRA_LAT);
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_q <= result_d;
                        bcond_q  <= bcond_d;
`ifdef ALU_FLAGS_EN
                        flags_q  <= flags_d;
`endif
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign bcond     = bcond_q;
`ifdef ALU_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: two instances (EXTRA_LAT 0 and 3), directed and
// random ops checked against an integer reference model. Checks flags when ALU_FLAGS_EN is defined.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int W    = 16;
    localparam int LAT0 = 0;
    localparam int LAT1 = 3;

    typedef struct {
        logic [15:0] res;
        logic        bc;
        logic [3:0]  fl;
        int          acc;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        bc;
    } dir_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][3:0]  op_code;
    logic [1:0][15:0] op_a;
    logic [1:0][15:0] op_b;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][15:0] result;
    logic [1:0]       bcond;
`ifdef ALU_FLAGS_EN
    logic [1:0][3:0]  flags;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rand_ready = 1'b0;
    bit   seen [2];
    int   last_acc [2];
    exp_t sb0 [$];
    exp_t sb1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_unit #(.WORD_SIZE(W), .EXTRA_LAT(LAT0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .op_code   (op_code[0]),
        .op_a      (op_a[0]),
        .op_b      (op_b[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .result    (result[0]),
        .bcond     (bcond[0])
`ifdef ALU_FLAGS_EN
        ,
        .flags     (flags[0])
`endif
    );

    alu_exec_unit #(.WORD_SIZE(W), .EXTRA_LAT(LAT1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .op_code   (op_code[1]),
        .op_a      (op_a[1]),
        .op_b      (op_b[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .result    (result[1]),
        .bcond     (bcond[1])
`ifdef ALU_FLAGS_EN
        ,
        .flags     (flags[1])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int idx);
        return (idx == 0) ? LAT0 : LAT1;
    endfunction

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r  = 0;
        int sr = 0;
        bit c  = 1'b0;
        bit v  = 1'b0;
        e.bc  = 1'b0;
        e.acc = 0;
        case (op)
            OP_ADD, OP_ADI, OP_MEM: begin
                r  = ua + ub;
                c  = (r > 65535);
                sr = sa + sb;
                v  = (sr > 32767) || (sr < -32768);
            end
            OP_SUB, OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                r  = ua - ub;
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr > 32767) || (sr < -32768);
            end
            OP_AND:         r = ua & ub;
            OP_ORR, OP_ORI: r = ua | ub;
            OP_NOT:         r = 65535 - ua;
            OP_TCP:         r = 65536 - ua;
            OP_SHL:         r = ua * 2;
            OP_SHR:         r = sa >>> 1;
            OP_LHI:         r = (ub % 256) * 256;
            default:        r = 0;
        endcase
        case (op)
            OP_BNE:  e.bc = (ua != ub);
            OP_BEQ:  e.bc = (ua == ub);
            OP_BGZ:  e.bc = (sa > 0);
            OP_BLZ:  e.bc = (sa < 0);
            default: e.bc = 1'b0;
        endcase
        e.res = 16'(r);
        e.fl  = {e.res == 16'h0000, e.res[15], c, v};
        return e;
    endfunction

    function automatic int sb_size(input int idx);
        return (idx == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic void sb_push(input int idx, input exp_t e);
        if (idx == 0) sb0.push_back(e);
        else          sb1.push_back(e);
    endfunction

    function automatic exp_t sb_front(input int idx);
        if (idx == 0) return sb0[0];
        return sb1[0];
    endfunction

    function automatic void sb_pop(input int idx);
        if (idx == 0) void'(sb0.pop_front());
        else          void'(sb1.pop_front());
    endfunction

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at posedge+1; holds the request until the unit is ready, then scrambles the inputs.
    task automatic issue(input int idx, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input exp_t e);
        int budget = 0;
        in_valid[idx] = 1'b1;
        op_code[idx]  = op;
        op_a[idx]     = a;
        op_b[idx]     = b;
        while (!in_ready[idx] && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready[idx]) begin
            check($sformatf("accept_timeout%0d", idx), in_ready[idx], 1'b1);
        end else begin
            e.acc         = cyc + 1;
            last_acc[idx] = e.acc;
            sb_push(idx, e);
        end
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        op_code[idx]  = 4'($urandom);
        op_a[idx]     = 16'($urandom);
        op_b[idx]     = 16'($urandom);
    endtask

    task automatic wait_drain(input int idx);
        int budget = 0;
        while (sb_size(idx) != 0 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        check($sformatf("drain%0d", idx), sb_size(idx), 0);
    endtask

    task automatic monitor_port(input int idx);
        exp_t e;
        if (out_valid[idx]) begin
            if (sb_size(idx) == 0) begin
                check($sformatf("unexpected_out%0d", idx), out_valid[idx], 1'b0);
            end else begin
                e = sb_front(idx);
                if (!seen[idx]) begin
                    check($sformatf("latency%0d", idx), cyc - e.acc, 1 + lat_of(idx));
                    seen[idx] = 1'b1;
                end
                check($sformatf("result%0d", idx), result[idx], e.res);
                check($sformatf("bcond%0d", idx), bcond[idx], e.bc);
`ifdef ALU_FLAGS_EN
                check($sformatf("flags%0d", idx), flags[idx], e.fl);
`endif
                if (out_ready[idx]) begin
                    sb_pop(idx);
                    seen[idx] = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            monitor_port(0);
            monitor_port(1);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 2'($urandom);
    end

    dir_t dirs [10] = '{
        '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0},
        '{OP_SHR, 16'h8002, 16'h0000, 16'hC001, 1'b0},
        '{OP_SHL, 16'h8001, 16'h0000, 16'h0002, 1'b0},
        '{OP_TCP, 16'h0001, 16'h0000, 16'hFFFF, 1'b0},
        '{OP_LHI, 16'h5555, 16'h12AB, 16'hAB00, 1'b0},
        '{OP_BEQ, 16'h0005, 16'h0005, 16'h0000, 1'b1},
        '{OP_BNE, 16'h0005, 16'h0005, 16'h0000, 1'b0},
        '{OP_BGZ, 16'h0000, 16'h0003, 16'hFFFD, 1'b0},
        '{OP_BGZ, 16'h0001, 16'h0000, 16'h0001, 1'b1},
        '{OP_BLZ, 16'h8000, 16'h0000, 16'h8000, 1'b1}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        int          accs [5];
        int          idx;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;

        reset     = 1'b1;
        in_valid  = '0;
        op_code   = '0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 2'b11;
        seen[0]   = 1'b0;
        seen[1]   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_in_ready%0d", i), in_ready[i], 1'b1);
            check($sformatf("rst_out_valid%0d", i), out_valid[i], 1'b0);
            check($sformatf("rst_result%0d", i), result[i], 16'h0000);
            check($sformatf("rst_bcond%0d", i), bcond[i], 1'b0);
        end

        // Directed arithmetic and branch cases on the zero-latency unit.
        foreach (dirs[k]) begin
            e     = model(dirs[k].op, dirs[k].a, dirs[k].b);
            e.res = dirs[k].res;
            e.bc  = dirs[k].bc;
            issue(0, dirs[k].op, dirs[k].a, dirs[k].b, e);
        end
        wait_drain(0);

        // Hold the result in DONE for 10 cycles with stray requests on the input.
        out_ready[0] = 1'b0;
        issue(0, OP_ADD, 16'h1234, 16'h1111, model(OP_ADD, 16'h1234, 16'h1111));
        for (int i = 0; i < 20 && !out_valid[0]; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", out_valid[0], 1'b1);
            check("hold_in_ready", in_ready[0], 1'b0);
            in_valid[0] = 1'(i % 2);
            op_code[0]  = OP_NOT;
            op_a[0]     = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid[0]  = 1'b1;
        op_code[0]   = OP_ORR;
        op_a[0]      = 16'hF0F0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("resume_in_ready", in_ready[0], 1'b1);
        issue(0, OP_SUB, 16'h0010, 16'h0020, model(OP_SUB, 16'h0010, 16'h0020));
        check("resume_accept_cycle", last_acc[0], cyc);
        wait_drain(0);

        // Leave a non-zero result in the slow unit, then reset it mid-EXEC.
        issue(1, OP_SUB, 16'h0009, 16'h0002, model(OP_SUB, 16'h0009, 16'h0002));
        wait_drain(1);
        in_valid[1] = 1'b1;
        op_code[1]  = OP_ADD;
        op_a[1]     = 16'h0003;
        op_b[1]     = 16'h0004;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("busy_before_reset", in_ready[1], 1'b0);
        reset = 1'b1;
        #1;
        check("midexec_rst_out_valid", out_valid[1], 1'b0);
        check("midexec_rst_result", result[1], 16'h0000);
        check("midexec_rst_in_ready", in_ready[1], 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midexec_no_output", out_valid[1], 1'b0);

        // Back-to-back ops on the slow unit with out_ready held high.
        out_ready[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            op = 4'($urandom);
            a  = rand_word();
            b  = rand_word();
            issue(1, op, a, b, model(op, a, b));
            accs[k] = last_acc[1];
        end
        for (int k = 1; k < 5; k++) begin
            check("b2b_period", accs[k] - accs[k-1], 3 + LAT1);
        end
        wait_drain(1);

        // Random ops on both units with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 120; n++) begin
            idx = $urandom_range(0, 1);
            op  = 4'($urandom);
            a   = rand_word();
            b   = ($urandom_range(0, 3) == 0) ? a : rand_word();
            issue(idx, op, a, b, model(op, a, b));
        end
        rand_ready = 1'b0;
        out_ready  = 2'b11;
        wait_drain(0);
        wait_drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
